// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types and default constants for the GPU instruction scheduler.
//   sched_state_t     - scheduler FSM encoding (IDLE / ISSUE / FENCE)
//   gpu_ins_t         - 32-bit GPU instruction word
//   FENCE_OP_DEFAULT  - INS[31:28] value that marks a fence
//   V_ACTIVE_DEFAULT  - first SYS_Y row that lies in vertical blanking
package gpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_FENCE = 2'd2
    } sched_state_t;

    typedef logic [31:0] gpu_ins_t;

    localparam logic [3:0] FENCE_OP_DEFAULT = 4'hF;
    localparam int         V_ACTIVE_DEFAULT = 480;

endpackage

// File: rtl/gpu_ins_scheduler_if.sv
// gpu_ins_scheduler_if: CPU-side push port, control-unit issue port and status
// of the GPU instruction scheduler, bundled as one interface.
//   slave  modport - seen by the scheduler
//   master modport - seen by the CPU / instruction control unit side
// Handshakes: a word moves on a rising clock edge exactly when VALID and READY
// are both high; the source holds VALID and data stable until that edge, and
// READY may not depend on VALID.
// Optional: GPU_SCHED_STATS_EN adds ISSUED_CNT (handshakes since frame start).
interface gpu_ins_scheduler_if #(
    parameter int DEPTH = 16
);
    import gpu_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic          INS_VALID;
    gpu_ins_t      INS;
    logic          INS_READY;
    logic          ISS_VALID;
    gpu_ins_t      ISS_INS;
    logic          ISS_READY;
    logic [CW-1:0] FIFO_COUNT;
    logic          OVERFLOW;
    sched_state_t  state_dbg;
`ifdef GPU_SCHED_STATS_EN
    logic [15:0]   ISSUED_CNT;
`endif

    modport slave (
        input  INS_VALID, INS, ISS_READY,
        output INS_READY, ISS_VALID, ISS_INS, FIFO_COUNT, OVERFLOW, state_dbg
`ifdef GPU_SCHED_STATS_EN
        , output ISSUED_CNT
`endif
    );

    modport master (
        output INS_VALID, INS, ISS_READY,
        input  INS_READY, ISS_VALID, ISS_INS, FIFO_COUNT, OVERFLOW, state_dbg
`ifdef GPU_SCHED_STATS_EN
        , input ISSUED_CNT
`endif
    );

endinterface

// File: rtl/gpu_ins_fifo.sv
// gpu_ins_fifo: synchronous instruction FIFO, async active-low reset.
//   clk, rst_n  - clock / asynchronous reset (active low)
//   push, din   - write din at the clock edge (ignored when full unless popping)
//   pop, dout   - dout is the head entry; pop removes it at the clock edge
//   full, empty - occupancy flags
//   count       - occupancy, 0..DEPTH (extra bit tells full from empty)
module gpu_ins_fifo
    import gpu_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  gpu_ins_t                   din,
    input  logic                       pop,
    output gpu_ins_t                   dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    gpu_ins_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A write into a full FIFO only fits when a read frees the slot this cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/gpu_ins_scheduler.sv
// gpu_ins_scheduler: buffers CPU-posted GPU instructions and releases them to
// the instruction control unit only during vertical blanking.
//   CLK, RST     - pixel clock / asynchronous reset (active low)
//   SYS_X, SYS_Y - current scan position (only the row matters)
//   bus          - gpu_ins_scheduler_if.slave: INS_VALID/INS/INS_READY push
//                  port, ISS_VALID/ISS_INS/ISS_READY issue port, FIFO_COUNT,
//                  sticky OVERFLOW, state_dbg (FSM state), optional ISSUED_CNT
// Optional: define GPU_SCHED_STATS_EN to add ISSUED_CNT.
// A head word whose opcode is FENCE_OP is dropped without being offered and
// blocks further issue until the next frame starts.
module gpu_ins_scheduler
    import gpu_pkg::*;
#(
    parameter int         DEPTH    = 16,
    parameter int         V_ACTIVE = V_ACTIVE_DEFAULT,
    parameter logic [3:0] FENCE_OP = FENCE_OP_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [9:0]            SYS_X,
    input  logic [9:0]            SYS_Y,
    gpu_ins_scheduler_if.slave    bus
);
    localparam int         CW         = $clog2(DEPTH) + 1;
    localparam logic [9:0] V_ACTIVE_Y = 10'(V_ACTIVE);

    sched_state_t  state;
    sched_state_t  state_d;

    logic          blank;
    logic          blank_q;
    logic          frame_start;
    logic          ready_q;
    logic          ins_ready;
    logic          push;
    logic          pop;
    logic          load_iss;
    logic          iss_valid;
    logic          handshake;
    logic          head_is_fence;
    logic          overflow_q;
    gpu_ins_t      iss_ins_q;
    gpu_ins_t      fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          unused_sys_x;

    assign unused_sys_x = ^SYS_X;

    // Blanking and frame start
    assign blank       = (SYS_Y >= V_ACTIVE_Y);
    assign frame_start = blank_q && !blank;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            blank_q <= 1'b0;
        end else begin
            blank_q <= blank;
        end
    end

    // Push side. ready_q keeps INS_READY low while RST is asserted and for
    // the first edge after release.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign ins_ready = ready_q && !fifo_full;
    assign push      = bus.INS_VALID && ins_ready;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overflow_q <= 1'b0;
        end else if (bus.INS_VALID && ready_q && fifo_full) begin
            overflow_q <= 1'b1;
        end
    end

    gpu_ins_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .push  (push),
        .din   (bus.INS),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_is_fence = (fifo_head[31:28] == FENCE_OP);

    // FSM: state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // FSM: next state. A fence leaves IDLE regardless of blanking; an ordinary
    // word only starts an offer while blanking. An offer already in ISSUE
    // completes even if blanking ends.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (head_is_fence) begin
                        state_d = S_FENCE;
                    end else if (blank) begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (bus.ISS_READY) begin
                    state_d = S_IDLE;
                end
            end
            S_FENCE: begin
                if (frame_start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs. Returning to IDLE after every handshake guarantees a
    // cycle with ISS_VALID low between instructions.
    always_comb begin
        iss_valid = 1'b0;
        pop       = 1'b0;
        load_iss  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (head_is_fence) begin
                        pop = 1'b1;
                    end else if (blank) begin
                        load_iss = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                iss_valid = 1'b1;
                pop       = bus.ISS_READY;
            end
            default: ;
        endcase
    end

    assign handshake = iss_valid && bus.ISS_READY;

    // The head stays in the FIFO while offered; a registered copy keeps
    // ISS_INS stable and defined after reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            iss_ins_q <= '0;
        end else if (load_iss) begin
            iss_ins_q <= fifo_head;
        end
    end

`ifdef GPU_SCHED_STATS_EN
    logic [15:0] issued_cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            issued_cnt_q <= '0;
        end else if (frame_start) begin
            issued_cnt_q <= handshake ? 16'd1 : 16'd0;
        end else if (handshake && (issued_cnt_q != 16'hFFFF)) begin
            issued_cnt_q <= issued_cnt_q + 16'd1;
        end
    end

    assign bus.ISSUED_CNT = issued_cnt_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

    assign bus.INS_READY  = ins_ready;
    assign bus.ISS_VALID  = iss_valid;
    assign bus.ISS_INS    = iss_ins_q;
    assign bus.FIFO_COUNT = fifo_count;
    assign bus.OVERFLOW   = overflow_q;
    assign bus.state_dbg  = state;

endmodule
